// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU / ALU_Control pair between two requesters.
// Port 0 is the main datapath, port 1 the address/branch unit.
// Pipeline: arbitrate + load issue register, then capture the ALU result
// one clock later and pulse rvalid to the owning port.
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed priority (port 0
// always wins a conflict); otherwise conflicts are resolved round-robin.
module alu_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [2:0]       aluOp0,
    input  logic [2:0]       aluOp1,
    input  logic [2:0]       func0,
    input  logic [2:0]       func1,
    input  logic             shiftDirection0,
    input  logic             shiftDirection1,
    input  logic [WIDTH-1:0] opA0,
    input  logic [WIDTH-1:0] opB0,
    input  logic [WIDTH-1:0] opA1,
    input  logic [WIDTH-1:0] opB1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             rvalid0,
    output logic             rvalid1,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       aluOp,
    output logic [2:0]       func,
    output logic             shiftDirection,
    output logic [WIDTH-1:0] aluA,
    output logic [WIDTH-1:0] aluB,
    input  logic [WIDTH-1:0] aluResult
);

    logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic             rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic             issue_valid_q, issue_valid_d;
    logic             issue_owner_q, issue_owner_d;
    logic [2:0]       alu_op_q, alu_op_d, func_q, func_d;
    logic             shift_dir_q, shift_dir_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             elig0, elig1, win0, win1;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic             last_grant_q, last_grant_d;  // 1 = port 1 won last
`endif

    // Arbitration: a port whose grant is currently high has its request
    // already accepted, so it is masked out for this edge.
    always_comb begin
        elig0 = req0 & ~gnt0_q;
        elig1 = req1 & ~gnt1_q;
`ifdef ALU_ARB_FIXED_PRIO_EN
        win0 = elig0;
`else
        win0 = elig0 & (~elig1 | last_grant_q);
`endif
        win1 = elig1 & ~win0;
    end

    // Next-state for grant, issue and result stages.
    always_comb begin
        gnt0_d        = win0;
        gnt1_d        = win1;
        issue_valid_d = win0 | win1;
        issue_owner_d = issue_owner_q;
        alu_op_d      = alu_op_q;
        func_d        = func_q;
        shift_dir_d   = shift_dir_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        result_d      = result_q;
        rvalid0_d     = 1'b0;
        rvalid1_d     = 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
        last_grant_d  = last_grant_q;
`endif
        if (win0) begin
            issue_owner_d = 1'b0;
            alu_op_d      = aluOp0;
            func_d        = func0;
            shift_dir_d   = shiftDirection0;
            alu_a_d       = opA0;
            alu_b_d       = opB0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant_d  = 1'b0;
`endif
        end else if (win1) begin
            issue_owner_d = 1'b1;
            alu_op_d      = aluOp1;
            func_d        = func1;
            shift_dir_d   = shiftDirection1;
            alu_a_d       = opA1;
            alu_b_d       = opB1;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant_d  = 1'b1;
`endif
        end
        if (issue_valid_q) begin
            result_d  = aluResult;
            rvalid0_d = ~issue_owner_q;
            rvalid1_d = issue_owner_q;
        end
    end

    // State registers; reset drops any in-flight operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt0_q        <= 1'b0;
            gnt1_q        <= 1'b0;
            rvalid0_q     <= 1'b0;
            rvalid1_q     <= 1'b0;
            issue_valid_q <= 1'b0;
            issue_owner_q <= 1'b0;
            alu_op_q      <= '0;
            func_q        <= '0;
            shift_dir_q   <= 1'b0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            result_q      <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant_q  <= 1'b1;
`endif
        end else begin
            gnt0_q        <= gnt0_d;
            gnt1_q        <= gnt1_d;
            rvalid0_q     <= rvalid0_d;
            rvalid1_q     <= rvalid1_d;
            issue_valid_q <= issue_valid_d;
            issue_owner_q <= issue_owner_d;
            alu_op_q      <= alu_op_d;
            func_q        <= func_d;
            shift_dir_q   <= shift_dir_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            result_q      <= result_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant_q  <= last_grant_d;
`endif
        end
    end

    assign gnt0           = gnt0_q;
    assign gnt1           = gnt1_q;
    assign rvalid0        = rvalid0_q;
    assign rvalid1        = rvalid1_q;
    assign result         = result_q;
    assign aluOp          = alu_op_q;
    assign func           = func_q;
    assign shiftDirection = shift_dir_q;
    assign aluA           = alu_a_q;
    assign aluB           = alu_b_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU stand-in.
module tb_alu_arbiter;
    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0, req1;
    logic [2:0]       aluOp0, aluOp1, func0, func1;
    logic             shiftDirection0, shiftDirection1;
    logic [WIDTH-1:0] opA0, opB0, opA1, opB1;
    logic             gnt0, gnt1, rvalid0, rvalid1;
    logic [WIDTH-1:0] result, aluA, aluB, aluResult;
    logic [2:0]       aluOp, func;
    logic             shiftDirection;

    int errors = 0;
    int checks = 0;

    alu_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .aluOp0(aluOp0), .aluOp1(aluOp1), .func0(func0), .func1(func1),
        .shiftDirection0(shiftDirection0), .shiftDirection1(shiftDirection1),
        .opA0(opA0), .opB0(opB0), .opA1(opA1), .opB1(opB1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .result(result), .aluOp(aluOp), .func(func),
        .shiftDirection(shiftDirection), .aluA(aluA), .aluB(aluB),
        .aluResult(aluResult)
    );

    always #5 clk = ~clk;

    // ALU stand-in: 0 add, 1 subtract, 3 shift (dir 1 = left) by aluB[3:0].
    always_comb begin
        case (aluOp)
            3'd0:    aluResult = aluA + aluB;
            3'd1:    aluResult = aluA - aluB;
            3'd3:    aluResult = shiftDirection ? (aluA << aluB[3:0]) : (aluA >> aluB[3:0]);
            default: aluResult = '0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic r, input logic [2:0] op, input logic sd,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req0 = r; aluOp0 = op; func0 = 3'd2; shiftDirection0 = sd; opA0 = a; opB0 = b;
    endtask

    task automatic set1(input logic r, input logic [2:0] op, input logic sd,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req1 = r; aluOp1 = op; func1 = 3'd5; shiftDirection1 = sd; opA1 = a; opB1 = b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set0(1'b1, 3'd1, 1'b1, 16'h1234, 16'h0001);
        set1(1'b1, 3'd0, 1'b1, 16'h4321, 16'h0002);
        tick();
        tick();
        checks++;
        if ({gnt0, gnt1, rvalid0, rvalid1} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000", {gnt0, gnt1, rvalid0, rvalid1});
        end
        checks++;
        if ({result, aluA, aluB} !== 48'h0) begin
            errors++;
            $display("FAIL reset_data: got %h/%h/%h expected 0/0/0", result, aluA, aluB);
        end
        checks++;
        if ({aluOp, func, shiftDirection} !== 7'h0) begin
            errors++;
            $display("FAIL reset_ctrl: got op=%0d func=%0d sd=%0b expected 0", aluOp, func, shiftDirection);
        end
        set0(1'b0, 3'd0, 1'b0, '0, '0);
        set1(1'b0, 3'd0, 1'b0, '0, '0);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_port0();
        set0(1'b1, 3'd0, 1'b0, 16'h0005, 16'h0003);
        tick();
        checks++;
        if ({gnt0, gnt1, rvalid0, rvalid1} !== 4'b1000) begin
            errors++;
            $display("FAIL single_grant: got %b expected 1000", {gnt0, gnt1, rvalid0, rvalid1});
        end
        checks++;
        if ({aluOp, func, aluA, aluB} !== {3'd0, 3'd2, 16'h0005, 16'h0003}) begin
            errors++;
            $display("FAIL single_issue: got op=%0d func=%0d A=%h B=%h expected 0/2/0005/0003", aluOp, func, aluA, aluB);
        end
        set0(1'b0, 3'd0, 1'b0, '0, '0);
        tick();
        checks++;
        if ({gnt0, gnt1, rvalid0, rvalid1} !== 4'b0010 || result !== 16'h0008) begin
            errors++;
            $display("FAIL single_result: got flags=%b result=%h expected 0010/0008", {gnt0, gnt1, rvalid0, rvalid1}, result);
        end
        tick();
        checks++;
        if ({rvalid0, rvalid1} !== 2'b00 || result !== 16'h0008) begin
            errors++;
            $display("FAIL single_hold: got rv=%b result=%h expected 00/0008", {rvalid0, rvalid1}, result);
        end
    endtask

    task automatic test_conflict();
        do_reset();
        set0(1'b1, 3'd0, 1'b0, 16'd10, 16'd20);
        set1(1'b1, 3'd1, 1'b0, 16'd50, 16'd8);
        tick();
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            errors++;
            $display("FAIL conflict_c1: got gnt=%b expected 10", {gnt0, gnt1});
        end
        set0(1'b0, 3'd0, 1'b0, '0, '0);
        tick();
        checks++;
        if ({gnt0, gnt1, rvalid0, rvalid1} !== 4'b0110 || result !== 16'd30) begin
            errors++;
            $display("FAIL conflict_c2: got flags=%b result=%0d expected 0110/30", {gnt0, gnt1, rvalid0, rvalid1}, result);
        end
        set1(1'b0, 3'd0, 1'b0, '0, '0);
        tick();
        checks++;
        if ({gnt0, gnt1, rvalid0, rvalid1} !== 4'b0001 || result !== 16'd42) begin
            errors++;
            $display("FAIL conflict_c3: got flags=%b result=%0d expected 0001/42", {gnt0, gnt1, rvalid0, rvalid1}, result);
        end
        tick();
    endtask

    // Port 0 adds 100+1 = 101; port 1 shifts 8001 left by 1 = 0002 (MSB drops).
    task automatic test_back_to_back();
        logic exp_rv0, exp_rv1;
        do_reset();
        set0(1'b1, 3'd0, 1'b0, 16'd100, 16'd1);
        set1(1'b1, 3'd3, 1'b1, 16'h8001, 16'd1);
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if ({gnt0, gnt1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL b2b_grant[%0d]: got gnt=%b expected %b", i, {gnt0, gnt1}, (i % 2 == 0) ? 2'b10 : 2'b01);
            end
            exp_rv0 = (i > 0) && (i % 2 == 1);
            exp_rv1 = (i > 0) && (i % 2 == 0);
            checks++;
            if ({rvalid0, rvalid1} !== {exp_rv0, exp_rv1} ||
                (exp_rv0 && result !== 16'd101) || (exp_rv1 && result !== 16'h0002)) begin
                errors++;
                $display("FAIL b2b_result[%0d]: got rv=%b result=%h expected rv=%b", i, {rvalid0, rvalid1}, result, {exp_rv0, exp_rv1});
            end
        end
        set0(1'b0, 3'd0, 1'b0, '0, '0);
        set1(1'b0, 3'd0, 1'b0, '0, '0);
        tick();
        checks++;
        if ({gnt0, gnt1, rvalid0, rvalid1} !== 4'b0001 || result !== 16'h0002) begin
            errors++;
            $display("FAIL b2b_tail: got flags=%b result=%h expected 0001/0002", {gnt0, gnt1, rvalid0, rvalid1}, result);
        end
        tick();
    endtask

    // After a lone port 0 grant and an idle gap, a conflict goes to port 1
    // under round-robin but to port 0 under fixed priority.
    task automatic test_fairness();
        logic [1:0] exp_gnt;
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_gnt = 2'b10;
`else
        exp_gnt = 2'b01;
`endif
        do_reset();
        set0(1'b1, 3'd0, 1'b0, 16'd1, 16'd1);
        tick();
        set0(1'b0, 3'd0, 1'b0, '0, '0);
        tick();
        set0(1'b1, 3'd0, 1'b0, 16'd7, 16'd7);
        set1(1'b1, 3'd1, 1'b0, 16'd9, 16'd4);
        tick();
        checks++;
        if ({gnt0, gnt1} !== exp_gnt) begin
            errors++;
            $display("FAIL fair_conflict: got gnt=%b expected %b", {gnt0, gnt1}, exp_gnt);
        end
        if (gnt0) set0(1'b0, 3'd0, 1'b0, '0, '0);
        if (gnt1) set1(1'b0, 3'd0, 1'b0, '0, '0);
        tick();
        checks++;
        if ({gnt0, gnt1} !== ~exp_gnt) begin
            errors++;
            $display("FAIL fair_second: got gnt=%b expected %b", {gnt0, gnt1}, ~exp_gnt);
        end
        set0(1'b0, 3'd0, 1'b0, '0, '0);
        set1(1'b0, 3'd0, 1'b0, '0, '0);
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        set0(1'b1, 3'd0, 1'b0, 16'd3, 16'd4);
        set1(1'b1, 3'd1, 1'b0, 16'd20, 16'd5);
        tick();
        set0(1'b0, 3'd0, 1'b0, '0, '0);
        tick();
        checks++;
        if ({gnt0, gnt1} !== 2'b01) begin
            errors++;
            $display("FAIL mid_pre: got gnt=%b expected 01", {gnt0, gnt1});
        end
        rst_n = 1'b0;
        set0(1'b1, 3'd0, 1'b0, 16'd3, 16'd4);
        tick();
        checks++;
        if ({gnt0, gnt1, rvalid0, rvalid1} !== 4'b0000 || {result, aluA, aluB} !== 48'h0) begin
            errors++;
            $display("FAIL mid_reset: got flags=%b result=%h A=%h B=%h expected all 0", {gnt0, gnt1, rvalid0, rvalid1}, result, aluA, aluB);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({gnt0, gnt1, rvalid0, rvalid1} !== 4'b1000) begin
            errors++;
            $display("FAIL mid_after: got flags=%b expected 1000", {gnt0, gnt1, rvalid0, rvalid1});
        end
        set0(1'b0, 3'd0, 1'b0, '0, '0);
        set1(1'b0, 3'd0, 1'b0, '0, '0);
        tick();
        checks++;
        if ({rvalid0, rvalid1} !== 2'b10 || result !== 16'd7) begin
            errors++;
            $display("FAIL mid_result: got rv=%b result=%0d expected 10/7", {rvalid0, rvalid1}, result);
        end
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        set0(1'b0, 3'd0, 1'b0, '0, '0);
        set1(1'b0, 3'd0, 1'b0, '0, '0);
        test_reset();
        test_single_port0();
        test_conflict();
        test_back_to_back();
        test_fairness();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
